// File: rtl/usb_pipe_frame_scheduler.sv
// Frames pixel and telemetry words into the pipe-out FIFO: flush, header, round-robin stream, trailer.
// Optional build macro USB_PIPE_SCHED_CHECKSUM_EN adds an XOR checksum word to the trailer.
module usb_pipe_frame_scheduler #(
    parameter int unsigned FRAME_WORDS   = 1024,
    parameter int unsigned RST_CYCLES    = 16,
    parameter int unsigned SETTLE_CYCLES = 8,
    parameter logic [31:0] HDR_MAGIC     = 32'hA5A5_0001
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        start,
    input  logic        abort,
    input  logic        pix_valid,
    input  logic [31:0] pix_data,
    output logic        pix_ready,
    input  logic        tel_valid,
    input  logic [31:0] tel_data,
    output logic        tel_ready,
    input  logic        fifo_full,
    output logic        fifo_wr_en,
    output logic [31:0] fifo_din,
    output logic        fifo_wr_reset,
    output logic        fifo_rd_reset,
    output logic        busy,
    output logic        frame_done,
    output logic [15:0] frame_count,
    output logic        overflow
);
    typedef enum logic [2:0] {
        S_IDLE, S_FLUSH, S_SETTLE, S_HEADER, S_STREAM, S_TRAILER, S_DONE
    } state_t;

    localparam logic [31:0] RST_LAST    = 32'(RST_CYCLES - 1);
    localparam logic [31:0] SETTLE_LAST = 32'(SETTLE_CYCLES - 1);
    localparam logic [15:0] PIX_LAST    = 16'(FRAME_WORDS - 1);
`ifdef USB_PIPE_SCHED_CHECKSUM_EN
    localparam logic [31:0] TRL_LAST    = 32'd1;
`else
    localparam logic [31:0] TRL_LAST    = 32'd0;
`endif
    localparam logic GNT_PIX = 1'b0;
    localparam logic GNT_TEL = 1'b1;

    state_t      state_q, state_d;
    logic [31:0] cnt_q, cnt_d;
    logic [15:0] pix_count_q, pix_count_d;
    logic [15:0] tel_count_q, tel_count_d;
    logic [15:0] frame_count_q, frame_count_d;
    logic        last_grant_q, last_grant_d;
    logic        wr_en_q, wr_en_d;
    logic [31:0] din_q, din_d;
    logic        overflow_q, overflow_d;
`ifdef USB_PIPE_SCHED_CHECKSUM_EN
    logic [31:0] csum_q, csum_d;
`endif

    logic        grant;
    logic        stream_open;
    logic        pix_acc, tel_acc;
    logic [31:0] acc_word;
    logic        start_acc;

    // Round-robin: on a tie the source not granted last wins.
    always_comb begin
        if (pix_valid && tel_valid) begin
            grant = (last_grant_q == GNT_TEL) ? GNT_PIX : GNT_TEL;
        end else if (tel_valid) begin
            grant = GNT_TEL;
        end else begin
            grant = GNT_PIX;
        end
    end

    assign stream_open = (state_q == S_STREAM) && !fifo_full && !abort;
    assign pix_ready   = stream_open && (grant == GNT_PIX);
    assign tel_ready   = stream_open && (grant == GNT_TEL);
    assign pix_acc     = pix_valid && pix_ready;
    assign tel_acc     = tel_valid && tel_ready;
    assign acc_word    = pix_acc ? pix_data : tel_data;
    assign start_acc   = (state_q == S_IDLE) && start && !abort;

    always_comb begin
        state_d       = state_q;
        cnt_d         = cnt_q;
        pix_count_d   = pix_count_q;
        tel_count_d   = tel_count_q;
        frame_count_d = frame_count_q;
        last_grant_d  = last_grant_q;
        wr_en_d       = 1'b0;
        din_d         = din_q;
`ifdef USB_PIPE_SCHED_CHECKSUM_EN
        csum_d        = csum_q;
`endif
        case (state_q)
            S_IDLE: begin
                if (start_acc) begin
                    state_d     = S_FLUSH;
                    cnt_d       = '0;
                    pix_count_d = '0;
                    tel_count_d = '0;
`ifdef USB_PIPE_SCHED_CHECKSUM_EN
                    csum_d      = '0;
`endif
                end
            end
            S_FLUSH: begin
                if (cnt_q == RST_LAST) begin
                    cnt_d   = '0;
                    state_d = (SETTLE_CYCLES == 0) ? S_HEADER : S_SETTLE;
                end else begin
                    cnt_d = cnt_q + 32'd1;
                end
            end
            S_SETTLE: begin
                if (cnt_q == SETTLE_LAST) begin
                    cnt_d   = '0;
                    state_d = S_HEADER;
                end else begin
                    cnt_d = cnt_q + 32'd1;
                end
            end
            S_HEADER: begin
                if (!fifo_full) begin
                    wr_en_d = 1'b1;
                    if (cnt_q == 32'd0) begin
                        din_d = HDR_MAGIC;
                        cnt_d = 32'd1;
                    end else begin
                        din_d   = {16'h0, frame_count_q};
                        cnt_d   = '0;
                        state_d = S_STREAM;
                    end
                end
            end
            S_STREAM: begin
                if (pix_acc || tel_acc) begin
                    wr_en_d      = 1'b1;
                    din_d        = acc_word;
                    last_grant_d = grant;
`ifdef USB_PIPE_SCHED_CHECKSUM_EN
                    csum_d       = csum_q ^ acc_word;
`endif
                    if (pix_acc) begin
                        pix_count_d = pix_count_q + 16'd1;
                        if (pix_count_q == PIX_LAST) begin
                            state_d = S_TRAILER;
                        end
                    end else if (tel_count_q != 16'hFFFF) begin
                        tel_count_d = tel_count_q + 16'd1;
                    end
                end
            end
            S_TRAILER: begin
                if (!fifo_full) begin
                    wr_en_d = 1'b1;
`ifdef USB_PIPE_SCHED_CHECKSUM_EN
                    din_d = (cnt_q == 32'd0) ? {tel_count_q, pix_count_q} : csum_q;
`else
                    din_d = {tel_count_q, pix_count_q};
`endif
                    if (cnt_q == TRL_LAST) begin
                        cnt_d         = '0;
                        state_d       = S_DONE;
                        frame_count_d = frame_count_q + 16'd1;
                    end else begin
                        cnt_d = cnt_q + 32'd1;
                    end
                end
            end
            S_DONE: begin
                state_d = S_IDLE;
            end
            default: begin
                state_d = S_IDLE;
            end
        endcase

        // Abort kills any commit in this cycle; a word registered last cycle still goes out.
        if (abort && (state_q != S_IDLE)) begin
            state_d       = S_IDLE;
            cnt_d         = '0;
            wr_en_d       = 1'b0;
            din_d         = din_q;
            frame_count_d = frame_count_q;
        end
    end

    // Sticky margin violation: the registered write landed while the FIFO reported almost-full.
    assign overflow_d = start_acc ? 1'b0 : (overflow_q | (wr_en_q & fifo_full));

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q       <= S_IDLE;
            cnt_q         <= '0;
            pix_count_q   <= '0;
            tel_count_q   <= '0;
            frame_count_q <= '0;
            last_grant_q  <= GNT_TEL;
            wr_en_q       <= 1'b0;
            din_q         <= '0;
            overflow_q    <= 1'b0;
`ifdef USB_PIPE_SCHED_CHECKSUM_EN
            csum_q        <= '0;
`endif
        end else begin
            state_q       <= state_d;
            cnt_q         <= cnt_d;
            pix_count_q   <= pix_count_d;
            tel_count_q   <= tel_count_d;
            frame_count_q <= frame_count_d;
            last_grant_q  <= last_grant_d;
            wr_en_q       <= wr_en_d;
            din_q         <= din_d;
            overflow_q    <= overflow_d;
`ifdef USB_PIPE_SCHED_CHECKSUM_EN
            csum_q        <= csum_d;
`endif
        end
    end

    assign fifo_wr_en    = wr_en_q;
    assign fifo_din      = din_q;
    assign fifo_wr_reset = (state_q == S_FLUSH);
    assign fifo_rd_reset = (state_q == S_FLUSH);
    assign busy          = (state_q != S_IDLE);
    assign frame_done    = (state_q == S_DONE);
    assign frame_count   = frame_count_q;
    assign overflow      = overflow_q;
endmodule
